// File: rtl/alu_op_sequencer.sv
// Purpose: sequences A -> B -> op entry from debounced buttons, holds ALU inputs, captures result/flags.
// Latency: raw press to accept = 2 + DEBOUNCE_CYCLES + 1 cycles; p_op accept to done = EXEC_CYCLES + 1 cycles.
// Backpressure: none; presses not expected in the current state are dropped and latch the sticky err flag.
module alu_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int EXEC_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic        btn_op,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_flags,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [3:0]  op,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [2:0]  state,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_WAIT_A  = 3'd0;
  localparam logic [2:0] S_WAIT_B  = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_SHOW    = 3'd5;

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ECW = $clog2(EXEC_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ECW-1:0] EXEC_LAST = ECW'(EXEC_CYCLES - 1);

  // Button lanes: bit 0 = A, bit 1 = B, bit 2 = op.
  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q, db_q, db_prev_q;
  logic [DCW-1:0] db_cnt_q [3];
  logic [2:0]     pulse;

  assign btn_raw = {btn_op, btn_b, btn_a};
  assign pulse   = db_q & ~db_prev_q;

  // Synchronize, debounce and edge-register each button lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  logic [2:0]     state_q, state_d;
  logic [31:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [3:0]     op_q, op_d, flags_q, flags_d;
  logic [ECW-1:0] exec_cnt_q, exec_cnt_d;
  logic           done_q, done_d, err_q, err_d;
  logic [2:0]     accepted, rejected;

  // Next-state logic: accept only the press the state is waiting for; every other press flags err.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    op_d       = op_q;
    res_d      = res_q;
    flags_d    = flags_q;
    exec_cnt_d = exec_cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;
    accepted   = 3'b000;
    case (state_q)
      S_WAIT_A, S_SHOW: begin
        if (pulse[0]) begin
          accepted[0] = 1'b1;
          opa_d       = data;
          state_d     = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (pulse[1]) begin
          accepted[1] = 1'b1;
          opb_d       = data;
          state_d     = S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        if (pulse[2]) begin
          accepted[2] = 1'b1;
          op_d        = data[31:28];
          exec_cnt_d  = EXEC_LAST;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_cnt_q == '0) state_d = S_CAPTURE;
        else                  exec_cnt_d = exec_cnt_q - ECW'(1);
      end
      S_CAPTURE: begin
        res_d   = alu_res;
        flags_d = alu_flags;
        done_d  = 1'b1;
        state_d = S_SHOW;
      end
      default: state_d = S_WAIT_A;
    endcase
    rejected = pulse & ~accepted;
    // A new A entry starts a fresh sequence, so it clears err unless a stray press arrives with it.
    if (accepted[0])    err_d = |rejected;
    else if (|rejected) err_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT_A;
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      exec_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      op_q       <= op_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      exec_cnt_q <= exec_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign op        = op_q;
  assign result    = res_q;
  assign flags     = flags_q;
  assign state     = state_q;
  assign busy      = (state_q == S_EXEC) || (state_q == S_CAPTURE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Single-clock controller that sequences operand/opcode entry and execution for the shared 32-bit ALU on the board. It takes three raw push-button inputs plus the 32-bit switch bus, and synchronizes and debounces the buttons. It enforces the entry order A → B → op, then holds the ALU inputs stable for a settle window. Finally it captures result and flags into registers that feed the LED display. It replaces the per-button strobe clocking of the ALU input registers, so that all state lives in the `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 200000: number of consecutive `clk` cycles a synchronized button level must be stable before it is accepted; legal range ≥1.
- `EXEC_CYCLES`, default 4: number of cycles the ALU inputs are held before capture; legal range ≥1.
- `clk` input 1: system clock; all state is on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `data` input 32: switch bus, sampled on the cycle a press is accepted.
- `btn_a`, `btn_b`, `btn_op` input 1 each: raw, asynchronous, bouncing buttons.
- `alu_res` input 32: ALU result (combinational from `operand_a`, `operand_b`, `op`).
- `alu_flags` input 4: ALU flags.
- `operand_a`, `operand_b` output 32: ALU operand registers.
- `op` output 4: ALU opcode register, loaded from `data[31:28]`.
- `result` output 32: captured result, to the display.
- `flags` output 4: captured flags.
- `state` output 3: current FSM state encoding.
- `busy` output 1: high in EXEC and CAPTURE.
- `done` output 1: one-cycle pulse when `result`/`flags` update.
- `err` output 1: sticky; set on any out-of-order press.

## Operation
- **Per-button input chain:** 2-FF synchronizer, then debounce counter, then a registered debounced level, then a rising-edge pulse `p_a`/`p_b`/`p_op` one cycle wide.
  - Debounce: while the synced level differs from the debounced level, the counter increments; any match clears it. When the counter reaches `DEBOUNCE_CYCLES-1` with the levels still differing, the debounced level takes the synced value and the counter clears.
  - A rising edge of the debounced level produces one pulse. Falling edges produce nothing.
- **FSM states:** WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, CAPTURE=4, SHOW=5.
  - WAIT_A or SHOW, `p_a`: `operand_a`←`data`; `err`←0; go to WAIT_B.
  - WAIT_B, `p_b`: `operand_b`←`data`; go to WAIT_OP.
  - WAIT_OP, `p_op`: `op`←`data[31:28]`; exec counter ← `EXEC_CYCLES-1`; go to EXEC.
  - EXEC: decrement the counter; when the counter is 0, go to CAPTURE.
  - CAPTURE: `result`←`alu_res`; `flags`←`alu_flags`; `done`←1; go to SHOW.
- **Out-of-order presses:** any pulse not accepted in the current state is ignored and sets `err`. This includes any pulse during EXEC or CAPTURE. Register contents are unchanged.
- **Simultaneous pulses:** the pulse expected by the state is accepted. Every other pulse in the same cycle sets `err`.
- **Stability guarantees:**
  - `operand_a`, `operand_b` and `op` never change in EXEC, CAPTURE or SHOW. The only exception is `operand_a` on a new `p_a` in SHOW.
  - `result` and `flags` change only in CAPTURE.
- **Arithmetic:** none inside the block. `data[31:28]` maps directly to `op`; the result width is passed through unchanged.

## Timing
- **Reset values:** all outputs 0; `state`=WAIT_A; synchronizers, debounced levels and counters 0. Reset assertion at any point, including mid-EXEC, returns to WAIT_A immediately and discards partial entries.
- **Button held across reset release:** yields exactly one pulse after 2 + `DEBOUNCE_CYCLES` cycles (+1 for the edge register).
- **Press latency:** a raw button edge to its accepted pulse takes 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles, with stable input.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- **Execution timing:** with `p_op` accepted at edge k:
  - `state`=EXEC for `EXEC_CYCLES` cycles.
  - `state`=CAPTURE after edge k+`EXEC_CYCLES`.
  - `result`, `flags` and `done`=1 valid after edge k+`EXEC_CYCLES`+1.
  - `done` falls at the next edge.
- **`busy`:** combinational from `state`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `EXEC_CYCLES`=2, and an ALU model where op 0 = add and op 1 = sub.
- **Nominal add:** `data`=5, press A; `data`=7, press B; `data`=32'h0000_0000, press op. Required: `result`=12, `done` pulses exactly once, 3 cycles after `p_op`, and `state` ends in SHOW.
- **Bounce rejection:** A toggled with pulses of 1–3 cycles, then held for 10 cycles. Required: exactly one `p_a` and one load of `operand_a`; `err`=0.
- **Out of order:** press B in WAIT_A with `data`=9. Required: `operand_b`=0, `state`=WAIT_A, `err`=1; a subsequent A press clears `err`.
- **Press during EXEC:** press A during EXEC. Required: `operand_a` unchanged, `result` = sum of the original operands, `err`=1.
- **Reset mid-EXEC:** assert `rst` in EXEC. Required: all outputs 0 and `state`=WAIT_A in the same cycle; no `done` after release.
- **Re-run from SHOW:** A=3, B=10, op=32'h1000_0000. Required: `result`=32'hFFFF_FFF9; the flags match the model.
